pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_pkg.sv | 20 ++
 rtl/pipe_reg_stage.sv | 50 +++++
 rtl/pipe_reg_chain.sv | 124 ++++++++++++
 tb/tb_pipe_reg_chain.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : pipe_reg_pkg                                                  |
// | Description : Shared constants and helpers for the pipe_reg_chain slice.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

package pipe_reg_pkg;

  localparam int C_DEFAULT_WIDTH = 8;
  localparam int C_DEFAULT_DEPTH = 3;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg_stage.sv
// +-----------------------------------------------------------------------------+
// | Module      : pipe_reg_stage                                                |
// | Description : One valid/data register pair with load enable and ready term.|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int              WIDTH   = C_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             next_rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // An empty stage always accepts, which is what collapses bubbles.
  assign rdy   = !r_valid || next_rdy;
  assign valid = r_valid;
  assign data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else if (rdy) begin
      r_valid <= src_valid;
      if (src_valid) begin
        r_data <= src_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// +-----------------------------------------------------------------------------+
// | Module      : pipe_reg_chain                                                |
// | Description : WIDTH x DEPTH valid/ready register pipeline, bubble-collapsing|
// |               Optional occupancy output occ_o via PIPE_REG_CHAIN_OCC_EN.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH   = C_DEFAULT_WIDTH,
  parameter int               DEPTH   = C_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ_o
`endif
);

  localparam int C_OCC_W = occ_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  stage_t w_stage [DEPTH];
  logic   w_rdy   [DEPTH+1];

  assign w_rdy[DEPTH] = out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;
    logic             w_valid;
    logic [WIDTH-1:0] w_data;

    if (k == 0) begin : g_head
      assign w_src_valid = in_valid_i && !flush_i;
      assign w_src_data  = in_data_i;
    end else begin : g_body
      assign w_src_valid = w_stage[k-1].valid;
      assign w_src_data  = w_stage[k-1].data;
    end

    pipe_reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .src_valid (w_src_valid),
      .src_data  (w_src_data),
      .next_rdy  (w_rdy[k+1]),
      .valid     (w_valid),
      .data      (w_data),
      .rdy       (w_rdy[k])
    );

    assign w_stage[k] = '{valid: w_valid, data: w_data};
  end

  // Flush blocks input so the producer never sees a word silently dropped.
  assign in_ready_o  = w_rdy[0] && !flush_i;
  assign out_valid_o = w_stage[DEPTH-1].valid;
  assign out_data_o  = w_stage[DEPTH-1].data;

`ifdef PIPE_REG_CHAIN_OCC_EN
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [C_OCC_W-1:0] r_occ;
  logic [DEPTH-1:0]   w_valid_vec;

  assign w_in_xfer  = in_valid_i && in_ready_o;
  assign w_out_xfer = out_valid_o && out_ready_i;
  assign occ_o      = r_occ;

  always_comb begin
    w_valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = w_stage[i].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush_i) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + C_OCC_W'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - C_OCC_W'(1);
    end
  end

  a_occ_bound : assert property (@(posedge clk) disable iff (rst)
    r_occ <= C_OCC_W'(DEPTH));

  a_occ_popcount : assert property (@(posedge clk) disable iff (rst)
    32'(r_occ) == $countones(w_valid_vec));
`else
  localparam int C_OCC_UNUSED = C_OCC_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_pipe_reg_chain                                             |
// | Description : Randomized self-checking bench; PIPE_REG_CHAIN_OCC_EN aware.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_reg_chain;
  import pipe_reg_pkg::*;

  localparam int         C_WIDTH = 8;
  localparam int         C_DEPTH = 3;
  localparam logic [7:0] C_RST   = 8'h3C;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [C_WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [C_WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [occ_width(C_DEPTH)-1:0] occ;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words in arrival order, each with its stage position.
  int         q_pos [$];
  logic [7:0] q_dat [$];

  pipe_reg_chain #(
    .WIDTH   (C_WIDTH),
    .DEPTH   (C_DEPTH),
    .RST_VAL (C_RST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occ_o       (occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A word advances whenever any stage ahead of it is empty or the output drains.
  task automatic model_edge(input bit in_x, input logic [7:0] d, input bit ordy, input bit fl);
    bit occupied [C_DEPTH];
    bit leave;
    if (fl) begin
      q_pos.delete();
      q_dat.delete();
      return;
    end
    for (int j = 0; j < C_DEPTH; j++) occupied[j] = 1'b0;
    foreach (q_pos[i]) occupied[q_pos[i]] = 1'b1;
    leave = 1'b0;
    foreach (q_pos[i]) begin
      bit room;
      room = ordy;
      for (int j = q_pos[i] + 1; j < C_DEPTH; j++) if (!occupied[j]) room = 1'b1;
      if (q_pos[i] == C_DEPTH - 1) begin
        if (ordy) leave = 1'b1;
      end else if (room) begin
        q_pos[i] = q_pos[i] + 1;
      end
    end
    if (leave) begin
      void'(q_pos.pop_front());
      void'(q_dat.pop_front());
    end
    if (in_x) begin
      q_pos.push_back(0);
      q_dat.push_back(d);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit ordy, input bit fl);
    bit exp_rdy;
    bit exp_ov;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = ((q_pos.size() < C_DEPTH) || ordy) && !fl;
    exp_ov  = (q_pos.size() > 0) && (q_pos[0] == C_DEPTH - 1);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(q_dat[0]));
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk("occ", 32'(occ), 32'(q_pos.size()));
`endif
    @(posedge clk);
    model_edge(v && exp_rdy, d, ordy, fl);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(C_RST));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Fill with 0xA5 under stall, then assert reset asynchronously mid-cycle.
    repeat (3) step(1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'(C_RST));
    chk("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_pos.delete();
    q_dat.delete();

    // Back-to-back throughput.
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Stall: four pushes, the fourth is refused until the output is released.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse: one word parked at the output, a second still accepted.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with two valid stages and a pending input.
    repeat (2) step(1'b1, 8'h5E, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'(C_RST));
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk("flush_occ", 32'(occ), 32'd0);
`endif

    // Random traffic with occasional flushes.
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 127) == 0);
    end
    repeat (C_DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", 32'(q_pos.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
